// File: rtl/nibble_add_sequencer.sv
// Nibble-serial adder controller: two requesters share one external 4-bit adder slice,
// round-robin arbitrated, LS nibble first with the carry recirculated through a register.
module nibble_add_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cin;
    logic             r_carry;
    logic             r_cout;
    logic             r_id;
    logic             r_last;
    logic [CW-1:0]    r_nib;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic             w_last_nib;
    logic [CW+1:0]    w_idx;

    // Round-robin: on contention the requester not served last time wins.
    assign w_gnt0     = req0_valid && (!req1_valid || r_last);
    assign w_gnt1     = req1_valid && (!req0_valid || !r_last);
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;
    assign w_accept   = w_acc0 || w_acc1;
    assign w_last_nib = (r_nib == LAST_NIB);
    assign w_idx      = {r_nib, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN:  if (w_last_nib) w_next = S_DONE;
            S_DONE: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        slice_a    = '0;
        slice_b    = '0;
        slice_cin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt0 && !rst;
                req1_ready = w_gnt1 && !rst;
            end
            S_RUN: begin
                busy      = 1'b1;
                slice_a   = r_a[w_idx +: 4];
                slice_b   = r_b[w_idx +: 4];
                slice_cin = (r_nib == '0) ? r_cin : r_carry;
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Result registers are only rewritten nibble by nibble in RUN, so they hold through DONE/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_nib   <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= w_acc1 ? req1_a   : req0_a;
                r_b    <= w_acc1 ? req1_b   : req0_b;
                r_cin  <= w_acc1 ? req1_cin : req0_cin;
                r_id   <= w_acc1;
                r_last <= w_acc1;
                r_nib  <= '0;
            end
            if (r_state == S_RUN) begin
                r_sum[w_idx +: 4] <= slice_sum;
                r_carry           <= slice_cout;
                r_nib             <= r_nib + 1'b1;
                if (w_last_nib) begin
                    r_cout <= slice_cout;
                end
            end
        end
    end

    assign res_sum  = r_sum;
    assign res_cout = r_cout;
    assign res_id   = r_id;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_add_sequencer;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             res_valid, res_ready, res_cout, res_id, busy;
    logic [WIDTH-1:0] res_sum;
    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_cin, slice_cout;

    int checks;
    int failures;

    nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .busy       (busy)
    );

    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({res_valid, busy, res_cout, res_id, req0_ready, req1_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {res_valid, busy, res_cout, res_id, req0_ready, req1_ready});
        end
        checks++;
        if ({res_sum, slice_a, slice_b, slice_cin} !== 25'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {res_sum, slice_a, slice_b, slice_cin});
        end
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ready got=%b exp=0", req0_ready);
        end
        rst = 1'b0; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL first_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic        vid  [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] va   [3] = '{16'h1234, 16'hFFFF, 16'h0FFF};
        logic [15:0] vb   [3] = '{16'h4321, 16'h0001, 16'h0000};
        logic        vci  [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] vsum [3] = '{16'h5555, 16'h0000, 16'h1000};
        logic        vco  [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0]  vmask[3] = '{4'b0000, 4'b1110, 4'b1111};
        logic [15:0] a, b;
        logic [3:0]  mask;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; mask = vmask[i];
            if (vid[i]) begin
                req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = vci[i];
            end else begin
                req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = vci[i];
            end
            #1;
            checks++;
            if ((vid[i] ? req1_ready : req0_ready) !== 1'b1) begin
                failures++;
                $display("FAIL arith%0d_ready got=%b exp=1", i, vid[i] ? req1_ready : req0_ready);
            end
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({res_valid, busy, slice_a, slice_b, slice_cin} !==
                    {1'b0, 1'b1, a[4*k +: 4], b[4*k +: 4], mask[k]}) begin
                    failures++;
                    $display("FAIL arith%0d_run%0d got v=%b busy=%b a=%h b=%h cin=%b exp a=%h b=%h cin=%b",
                             i, k, res_valid, busy, slice_a, slice_b, slice_cin,
                             a[4*k +: 4], b[4*k +: 4], mask[k]);
                end
                @(negedge clk);
            end
            checks++;
            if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, vsum[i], vco[i], vid[i]}) begin
                failures++;
                $display("FAIL arith%0d_result got v=%b sum=%h cout=%b id=%b exp v=1 sum=%h cout=%b id=%b",
                         i, res_valid, res_sum, res_cout, res_id, vsum[i], vco[i], vid[i]);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checks++;
            if ({res_valid, busy, res_sum} !== {1'b0, 1'b0, vsum[i]}) begin
                failures++;
                $display("FAIL arith%0d_post got v=%b busy=%b sum=%h exp v=0 busy=0 sum=%h",
                         i, res_valid, busy, res_sum, vsum[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int acc_cyc[$];
        logic acc_id[$];
        int overlap = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req0_ready && req1_ready) overlap++;
            if (req0_ready || req1_ready) begin
                acc_cyc.push_back(c);
                acc_id.push_back(req1_ready);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL rr_overlap got=%0d exp=0", overlap);
        end
        checks++;
        if (acc_cyc.size() < 4) begin
            failures++;
            $display("FAIL rr_count got=%0d exp>=4", acc_cyc.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (acc_id[j] !== j[0]) begin
                    failures++;
                    $display("FAIL rr_id%0d got=%b exp=%b", j, acc_id[j], j[0]);
                end
                if (j > 0) begin
                    checks++;
                    if (acc_cyc[j] - acc_cyc[j-1] !== 6) begin
                        failures++;
                        $display("FAIL rr_gap%0d got=%0d exp=6", j, acc_cyc[j] - acc_cyc[j-1]);
                    end
                end
            end
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0020; req0_cin = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h00AA; req1_b = 16'h0055; req1_cin = 1'b0;
        for (int c = 0; c < 10 && !res_valid; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({res_valid, res_sum, res_id, req0_ready, req1_ready} !== {1'b1, 16'h0030, 3'b000}) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b sum=%h id=%b rdy=%b%b exp v=1 sum=0030 id=0 rdy=00",
                         c, res_valid, res_sum, res_id, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({res_valid, busy, req1_ready, res_sum} !== {3'b001, 16'h0030}) begin
            failures++;
            $display("FAIL bp_release got v=%b busy=%b rdy1=%b sum=%h exp v=0 busy=0 rdy1=1 sum=0030",
                     res_valid, busy, req1_ready, res_sum);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        for (int c = 0; c < 10 && !res_valid; c++) @(negedge clk);
        checks++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 16'h00FF, 2'b01}) begin
            failures++;
            $display("FAIL bp_stalled_req got v=%b sum=%h cout=%b id=%b exp v=1 sum=00ff cout=0 id=1",
                     res_valid, res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, slice_a, slice_b} !== {1'b1, 4'h1, 4'h2}) begin
            failures++;
            $display("FAIL mid_run2 got busy=%b a=%h b=%h exp busy=1 a=1 b=2", busy, slice_a, slice_b);
        end
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ready got=%b exp=0", req0_ready);
        end
        @(negedge clk);
        checks++;
        if ({res_valid, busy, slice_a, slice_b, slice_cin, req0_ready} !== 12'h0) begin
            failures++;
            $display("FAIL mid_rst_state got v=%b busy=%b a=%h b=%h cin=%b rdy=%b exp all 0",
                     res_valid, busy, slice_a, slice_b, slice_cin, req0_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_regrant got=%b exp=1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        for (int c = 0; c < 10 && !res_valid; c++) @(negedge clk);
        checks++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 16'h0002, 2'b00}) begin
            failures++;
            $display("FAIL mid_rst_newop got v=%b sum=%h cout=%b id=%b exp v=1 sum=0002 cout=0 id=0",
                     res_valid, res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
